// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: one shared RotWord/SubWord/Rcon stage expands a
// cipher key into an 11-entry round-key bank, one round key per clock.
module aes_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // Forward S-box, row-major: byte 0x00 sits in the top 8 bits.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX_TABLE[idx -: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t         state_r;
  logic [127:0]   rk_r [0:10];
  logic [127:0]   prev_r;
  logic [7:0]     rcon_r;
  logic [3:0]     cnt_r;
  logic           key_ready_r;
  logic           busy_r;
  logic           done_r;
  logic           keys_valid_r;
  logic [127:0]   rd_data_r;

  logic           accept_s;
  logic [31:0]    rot_s;
  logic [31:0]    t_s;
  logic [31:0]    n0_s;
  logic [31:0]    n1_s;
  logic [31:0]    n2_s;
  logic [31:0]    n3_s;
  logic [127:0]   next_key_s;

  assign accept_s   = key_valid & key_ready_r;
  assign key_ready  = key_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign keys_valid = keys_valid_r;
  assign rd_data    = rd_data_r;

  // Shared round-key stage: next round key from the previous one.
  always_comb begin
    rot_s      = {prev_r[23:0], prev_r[31:24]};
    t_s        = subword(rot_s) ^ {rcon_r, 24'h000000};
    n0_s       = prev_r[127:96] ^ t_s;
    n1_s       = prev_r[95:64]  ^ n0_s;
    n2_s       = prev_r[63:32]  ^ n1_s;
    n3_s       = prev_r[31:0]   ^ n2_s;
    next_key_s = {n0_s, n1_s, n2_s, n3_s};
  end

  // Controller FSM, bank writes and handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      for (int i = 0; i < 11; i++) rk_r[i] <= 128'h0;
      prev_r       <= 128'h0;
      rcon_r       <= 8'h00;
      cnt_r        <= 4'd0;
      key_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      keys_valid_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, READY: begin
          if (accept_s) begin
            rk_r[0]      <= key_in;
            prev_r       <= key_in;
            rcon_r       <= 8'h01;
            cnt_r        <= 4'd1;
            keys_valid_r <= 1'b0;
            key_ready_r  <= 1'b0;
            busy_r       <= 1'b1;
            state_r      <= EXPAND;
          end
        end
        EXPAND: begin
          rk_r[cnt_r] <= next_key_s;
          prev_r      <= next_key_s;
          rcon_r      <= xtime(rcon_r);
          // Round 10 is the last write; cnt parks at 10 until the next accept.
          if (cnt_r == 4'd10) begin
            state_r      <= READY;
            keys_valid_r <= 1'b1;
            done_r       <= 1'b1;
            key_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        default: begin
          state_r     <= IDLE;
          key_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Registered read port; out-of-range indices read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= 128'h0;
    end else if (rd_idx <= 4'd10) begin
      rd_data_r <= rk_r[rd_idx];
    end else begin
      rd_data_r <= 128'h0;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl against FIPS-197 and all-zero key schedules.
module tb_aes_key_sched_ctrl;

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_data;

  int n_checks;
  int n_fail;

  logic [127:0] fips_rk [0:10];
  logic [127:0] zero_rk1;
  logic [127:0] zero_rk10;

  aes_key_sched_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a key at a falling edge; returns at the falling edge after the accept edge.
  task automatic send_key(input logic [127:0] k, input bit hold);
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) key_valid = 1'b0;
  endtask

  // Counts rising edges until done is seen (bounded); 20 means timeout.
  task automatic wait_done(output int cyc);
    cyc = 20;
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_key_ready: got %b want 1", key_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL reset_keys_valid: got %b want 0", keys_valid); end
    n_checks++; if (rd_data !== 128'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
  endtask

  task automatic test_fips();
    int cyc;
    send_key(fips_rk[0], 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fips_busy: got %b want 1", busy); end
    n_checks++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL fips_key_ready: got %b want 0", key_ready); end
    wait_done(cyc);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL fips_done_latency: got %0d want 10", cyc); end
    n_checks++; if (keys_valid !== 1'b1) begin n_fail++; $display("FAIL fips_keys_valid: got %b want 1", keys_valid); end
    n_checks++; if (busy !== 1'b0 || key_ready !== 1'b1) begin n_fail++; $display("FAIL fips_ready_state: got busy=%b ready=%b want 0/1", busy, key_ready); end
    rd_idx = 4'd1;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL fips_done_pulse: got %b want 0", done); end
    n_checks++; if (rd_data !== 128'ha0fafe1788542cb123a339392a6c7605) begin n_fail++; $display("FAIL fips_rk1: got %h want a0fafe1788542cb123a339392a6c7605", rd_data); end
    rd_idx = 4'd10;
    @(negedge clk);
    n_checks++; if (rd_data !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_fail++; $display("FAIL fips_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rd_data); end
  endtask

  task automatic test_read_port();
    for (int i = 0; i <= 10; i++) begin
      rd_idx = 4'(i);
      @(negedge clk);
      n_checks++; if (rd_data !== fips_rk[i]) begin n_fail++; $display("FAIL read_rk%0d: got %h want %h", i, rd_data, fips_rk[i]); end
    end
    rd_idx = 4'd11;
    @(negedge clk);
    n_checks++; if (rd_data !== 128'h0) begin n_fail++; $display("FAIL read_idx11: got %h want 0", rd_data); end
    rd_idx = 4'd15;
    @(negedge clk);
    n_checks++; if (rd_data !== 128'h0) begin n_fail++; $display("FAIL read_idx15: got %h want 0", rd_data); end
  endtask

  task automatic test_zero_key();
    int cyc;
    send_key(128'h0, 1'b0);
    n_checks++; if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL zero_keys_valid_clear: got %b want 0", keys_valid); end
    wait_done(cyc);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL zero_done_latency: got %0d want 10", cyc); end
    n_checks++; if (keys_valid !== 1'b1) begin n_fail++; $display("FAIL zero_keys_valid: got %b want 1", keys_valid); end
    rd_idx = 4'd1;
    @(negedge clk);
    n_checks++; if (rd_data !== zero_rk1) begin n_fail++; $display("FAIL zero_rk1: got %h want %h", rd_data, zero_rk1); end
    rd_idx = 4'd10;
    @(negedge clk);
    n_checks++; if (rd_data !== zero_rk10) begin n_fail++; $display("FAIL zero_rk10: got %h want %h", rd_data, zero_rk10); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    send_key(fips_rk[0], 1'b1);
    key_in = 128'h0;
    for (int k = 0; k < 10; k++) begin
      n_checks++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL stall_key_ready_c%0d: got %b want 0", k, key_ready); end
      if (k == 9) rd_idx = 4'd10;
      @(negedge clk);
    end
    n_checks++; if (done !== 1'b1 || key_ready !== 1'b1) begin n_fail++; $display("FAIL stall_done: got done=%b ready=%b want 1/1", done, key_ready); end
    n_checks++; if (rd_data !== zero_rk10) begin n_fail++; $display("FAIL stall_same_cycle_read: got %h want %h", rd_data, zero_rk10); end
    rd_idx = 4'd9;
    @(negedge clk);
    n_checks++; if (keys_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL stall_second_accept: got kv=%b busy=%b done=%b want 0/1/0", keys_valid, busy, done); end
    n_checks++; if (rd_data !== fips_rk[9]) begin n_fail++; $display("FAIL stall_first_rk9: got %h want %h", rd_data, fips_rk[9]); end
    key_valid = 1'b0;
    rd_idx = 4'd10;
    @(negedge clk);
    n_checks++; if (rd_data !== fips_rk[10]) begin n_fail++; $display("FAIL stall_first_rk10: got %h want %h", rd_data, fips_rk[10]); end
    wait_done(cyc);
    n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL stall_second_done: got %0d want 9", cyc); end
    @(negedge clk);
    n_checks++; if (rd_data !== zero_rk10) begin n_fail++; $display("FAIL stall_second_rk10: got %h want %h", rd_data, zero_rk10); end
    rd_idx = 4'd0;
    @(negedge clk);
    n_checks++; if (rd_data !== 128'h0) begin n_fail++; $display("FAIL stall_second_rk0: got %h want 0", rd_data); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit saw_done;
    rd_idx = 4'd10;
    send_key(fips_rk[0], 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (key_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_async_hs: got ready=%b busy=%b want 1/0", key_ready, busy); end
    n_checks++; if (done !== 1'b0 || keys_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_async_status: got done=%b kv=%b want 0/0", done, keys_valid); end
    n_checks++; if (rd_data !== 128'h0) begin n_fail++; $display("FAIL midrst_async_rd: got %h want 0", rd_data); end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: got %b want 0", saw_done); end
    n_checks++; if (key_ready !== 1'b1 || busy !== 1'b0 || keys_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got ready=%b busy=%b kv=%b want 1/0/0", key_ready, busy, keys_valid); end
    n_checks++; if (rd_data !== 128'h0) begin n_fail++; $display("FAIL midrst_bank_clear: got %h want 0", rd_data); end
    send_key(fips_rk[0], 1'b0);
    wait_done(cyc);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL midrst_redo_latency: got %0d want 10", cyc); end
    @(negedge clk);
    n_checks++; if (rd_data !== fips_rk[10]) begin n_fail++; $display("FAIL midrst_redo_rk10: got %h want %h", rd_data, fips_rk[10]); end
  endtask

  task automatic test_rcon_wrap();
    for (int i = 7; i <= 10; i++) begin
      rd_idx = 4'(i);
      @(negedge clk);
      n_checks++; if (rd_data !== fips_rk[i]) begin n_fail++; $display("FAIL rcon_rk%0d: got %h want %h", i, rd_data, fips_rk[i]); end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    key_in    = 128'h0;
    key_valid = 1'b0;
    rd_idx    = 4'd0;
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zero_rk1    = 128'h62636363626363636263636362636363;
    zero_rk10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_fips();
    test_read_port();
    test_zero_key();
    test_back_to_back();
    test_reset_mid();
    test_rcon_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
